ias_fetch_unit: RTL and testbench
=================================

IAS_FETCH_UNIT -- requirements
Module: ias_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: HALT_OPCODE, default 8'hFF, opcode that stops fetching.
REQ-002 The block SHALL have the port clk, input, 1 bit: sole clock, rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have the port run, input, 1 bit: permits a new word fetch.
REQ-005 The block SHALL have the port pc_addr, input, 8 bits: current PC value from the program counter.
REQ-006 The block SHALL have the port inc_pc, output, 1 bit: PC increment pulse.
REQ-007 The block SHALL have the port load_pc, output, 1 bit: PC load pulse.
REQ-008 The block SHALL have the port jump_addr, output, 8 bits: PC load value.
REQ-009 The block SHALL have the port mem_rd_en, output, 1 bit: memory read request.
REQ-010 The block SHALL have the port mem_addr, output, 8 bits: memory read address.
REQ-011 The block SHALL have the port mem_rdata, input, 40 bits: memory word, left instruction [39:20], right instruction [19:0].
REQ-012 The block SHALL have the port mem_rvalid, input, 1 bit: mem_rdata valid.
REQ-013 The block SHALL have the port ir, output, 8 bits: issued opcode.
REQ-014 The block SHALL have the port mar, output, 12 bits: issued address field.
REQ-015 The block SHALL have the port instr_valid, output, 1 bit: ir/mar hold a live instruction.
REQ-016 The block SHALL have the port exec_done, input, 1 bit: executor finished the issued instruction.
REQ-017 The block SHALL have the port jump_req, input, 1 bit: taken jump, qualified by exec_done.
REQ-018 The block SHALL have the port jump_target, input, 8 bits: jump word address.
REQ-019 The block SHALL have the port jump_right, input, 1 bit: jump lands on the right half.
REQ-020 The block SHALL have the port halted, output, 1 bit: halt reached.

Function
REQ-021 The FSM states SHALL be IDLE, FETCH, WAIT_MEM, ISSUE_L, ISSUE_R, SETTLE, HALT.
REQ-022 IDLE with run=1 SHALL go to FETCH; with run=0 it SHALL remain in IDLE.
REQ-023 FETCH SHALL last exactly 1 cycle with mem_rd_en=1 and mem_addr=pc_addr, then go to WAIT_MEM.
REQ-024 WAIT_MEM SHALL hold until mem_rvalid=1, then perform all of the following:
- capture mem_rdata;
- load IBR with [19:0];
- pulse inc_pc for exactly 1 cycle on the next cycle;
- go to ISSUE_L, or to ISSUE_R when the right-only flag is set.
REQ-025 mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-026 ISSUE_L SHALL drive ir=left[19:12], mar=left[11:0], and instr_valid=1, held stable until exec_done.
REQ-027 ISSUE_R SHALL drive ir=IBR[19:12], mar=IBR[11:0], and instr_valid=1, held stable until exec_done.
REQ-028 exec_done with jump_req=0 SHALL advance the FSM: ISSUE_L to ISSUE_R; ISSUE_R to IDLE.
REQ-029 exec_done with jump_req=1 in either ISSUE state SHALL, on the next cycle:
- set load_pc=1 for exactly 1 cycle, with jump_addr=jump_target;
- set the right-only flag to jump_right;
- discard IBR;
- enter SETTLE.
REQ-030 SETTLE SHALL last 1 cycle, so that pc_addr reflects the load, then go to IDLE.
REQ-031 The right-only flag SHALL clear when ISSUE_R is entered.
REQ-032 exec_done while ir==HALT_OPCODE SHALL take priority over jump_req and SHALL go to HALT.
REQ-033 HALT SHALL hold halted=1 and instr_valid=0, and SHALL issue no memory requests or PC pulses until reset.
REQ-034 exec_done and jump_req outside the ISSUE states SHALL be ignored.
REQ-035 instr_valid SHALL drop in the cycle after exec_done is sampled.
REQ-036 inc_pc and load_pc SHALL never be high in the same cycle.
REQ-037 run SHALL be sampled only in IDLE; deasserting run mid-word SHALL complete both halves.
REQ-038 pc_addr wrap from 8'hFF to 8'h00 SHALL be handled by the PC; the fetch unit SHALL treat pc_addr as an opaque address.

Reset
REQ-039 reset=1 at a clock edge SHALL, in any state including mid-WAIT_MEM or HALT, set:
- state to IDLE;
- IBR to 0 and the right-only flag to 0;
- ir, mar, instr_valid, inc_pc, load_pc, jump_addr, mem_rd_en, mem_addr, and halted to 0.
REQ-040 A mem_rvalid arriving after reset SHALL be discarded.

Verification
REQ-041 Sequential fetch: pc_addr=8'h05, mem_rdata=40'h01_00A_02_00B, exec_done pulses -> one mem_rd_en with mem_addr=8'h05, inc_pc 1 cycle, ir=8'h01/mar=12'h00A, then ir=8'h02/mar=12'h00B, then IDLE.
REQ-042 Left jump: exec_done+jump_req with jump_target=8'h20, jump_right=0 during ISSUE_L -> load_pc 1 cycle with jump_addr=8'h20, SETTLE, then fetch at 8'h20 issuing the left half; old IBR never issued.
REQ-043 Right jump: jump_target=8'h30, jump_right=1 -> after fetch at 8'h30 only ir=mem_rdata[19:12] issues, then IDLE.
REQ-044 Halt: left opcode 8'hFF, exec_done -> halted=1, no further mem_rd_en for 20 cycles with run=1.
REQ-045 Reset mid-operation: reset during WAIT_MEM, then mem_rvalid next cycle -> all outputs 0, no issue, fetch restarts from pc_addr when run=1.
REQ-046 Stall: mem_rvalid delayed 7 cycles and exec_done delayed 5 cycles -> ir, mar and mem state stable throughout; no extra inc_pc.

Source files
------------

// File: rtl/ias_fetch_unit.sv
// IAS-style instruction fetch: reads a 40-bit word holding two 20-bit
// instructions and issues the left half, then the right half from the IBR.
module ias_fetch_unit #(
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  pc_addr,
    output logic        inc_pc,
    output logic        load_pc,
    output logic [7:0]  jump_addr,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [39:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [7:0]  ir,
    output logic [11:0] mar,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        jump_req,
    input  logic [7:0]  jump_target,
    input  logic        jump_right,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ISSUE_L,
        ISSUE_R,
        SETTLE,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] left_q, left_d;
    logic [19:0] ibr_q, ibr_d;
    logic        ronly_q, ronly_d;
    logic        inc_q, inc_d;
    logic        load_q, load_d;
    logic [7:0]  jaddr_q, jaddr_d;

    logic issuing;
    logic halt_hit;
    logic jump_hit;

    assign issuing  = (state_q == ISSUE_L) || (state_q == ISSUE_R);
    assign halt_hit = issuing && exec_done && (ir == HALT_OPCODE);
    assign jump_hit = issuing && exec_done && jump_req && !halt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            left_q  <= '0;
            ibr_q   <= '0;
            ronly_q <= 1'b0;
            inc_q   <= 1'b0;
            load_q  <= 1'b0;
            jaddr_q <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            ibr_q   <= ibr_d;
            ronly_q <= ronly_d;
            inc_q   <= inc_d;
            load_q  <= load_d;
            jaddr_q <= jaddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        ibr_d   = ibr_q;
        ronly_d = ronly_q;
        inc_d   = 1'b0;
        load_d  = 1'b0;
        jaddr_d = jaddr_q;
        unique case (state_q)
            IDLE:     if (run) state_d = FETCH;
            FETCH:    state_d = WAIT_MEM;
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    left_d  = mem_rdata[39:20];
                    ibr_d   = mem_rdata[19:0];
                    inc_d   = 1'b1;
                    state_d = ronly_q ? ISSUE_R : ISSUE_L;
                end
            end
            ISSUE_L, ISSUE_R: begin
                if (halt_hit) begin
                    state_d = HALT;
                end else if (jump_hit) begin
                    state_d = SETTLE;
                end else if (exec_done) begin
                    state_d = (state_q == ISSUE_L) ? ISSUE_R : IDLE;
                end
            end
            SETTLE:   state_d = IDLE;
            HALT:     state_d = HALT;
            default:  state_d = IDLE;
        endcase
        if (state_d == ISSUE_R && state_q != ISSUE_R) ronly_d = 1'b0;
        // A taken jump drops the buffered right half and arms right-only entry
        if (jump_hit) begin
            load_d  = 1'b1;
            jaddr_d = jump_target;
            ronly_d = jump_right;
            ibr_d   = '0;
        end
    end

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        ir          = '0;
        mar         = '0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = pc_addr;
            end
            ISSUE_L: begin
                ir          = left_q[19:12];
                mar         = left_q[11:0];
                instr_valid = 1'b1;
            end
            ISSUE_R: begin
                ir          = ibr_q[19:12];
                mar         = ibr_q[11:0];
                instr_valid = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign inc_pc    = inc_q;
    assign load_pc   = load_q;
    assign jump_addr = jaddr_q;

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Directed bench for ias_fetch_unit: table of sequential words plus
// hand-written jump, halt, reset and stall sequences.
module tb_ias_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  pc_addr;
    logic        inc_pc;
    logic        load_pc;
    logic [7:0]  jump_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [39:0] mem_rdata;
    logic        mem_rvalid;
    logic [7:0]  ir;
    logic [11:0] mar;
    logic        instr_valid;
    logic        exec_done;
    logic        jump_req;
    logic [7:0]  jump_target;
    logic        jump_right;
    logic        halted;

    always #5 clk = ~clk;

    ias_fetch_unit #(.HALT_OPCODE(8'hFF)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_addr(pc_addr),
        .inc_pc(inc_pc), .load_pc(load_pc), .jump_addr(jump_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .ir(ir), .mar(mar), .instr_valid(instr_valid),
        .exec_done(exec_done), .jump_req(jump_req),
        .jump_target(jump_target), .jump_right(jump_right),
        .halted(halted)
    );

    int checks = 0;
    int errors = 0;
    int n_inc = 0;
    int n_load = 0;
    int n_rd = 0;

    always @(negedge clk) begin
        if (inc_pc) n_inc++;
        if (load_pc) n_load++;
        if (mem_rd_en) n_rd++;
        checks++;
        if (inc_pc && load_pc) begin
            errors++;
            $display("FAIL inc_load_overlap: inc_pc=%0b load_pc=%0b required not both 1",
                     inc_pc, load_pc);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {inc_pc, load_pc, jump_addr, mem_rd_en, mem_addr,
                 ir, mar, instr_valid, halted}, 64'd0);
    endtask

    task automatic chk_issue(input string nm, input logic [7:0] eir,
                             input logic [11:0] emar);
        chk({nm, "_ir"}, ir, eir);
        chk({nm, "_mar"}, mar, emar);
        chk({nm, "_valid"}, instr_valid, 1'b1);
    endtask

    task automatic fetch(input logic [7:0] pc, input logic [39:0] data,
                         input int rdly);
        pc_addr = pc;
        run = 1'b1;
        tick();
        chk("fetch_rd_en", mem_rd_en, 1'b1);
        chk("fetch_addr", mem_addr, pc);
        run = 1'b0;
        mem_rdata = ~data;
        tick();
        chk("wait_rd_en", mem_rd_en, 1'b0);
        for (int k = 0; k < rdly; k++) begin
            tick();
            chk("wait_stall", {mem_rd_en, instr_valid, inc_pc}, 3'b000);
        end
        mem_rdata = data;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        chk("inc_pulse", inc_pc, 1'b1);
    endtask

    task automatic done(input logic jr);
        exec_done = 1'b1;
        jump_req = jr;
        tick();
        exec_done = 1'b0;
        jump_req = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  pc;
        logic [39:0] data;
        logic [7:0]  irl;
        logic [11:0] marl;
        logic [7:0]  irr;
        logic [11:0] marr;
        int          rdly;
        int          edly;
    } vec_t;

    vec_t vt[4];
    int   i0;
    int   r0;
    int   l0;

    initial begin
        reset = 1'b1; run = 1'b0; pc_addr = '0; mem_rdata = '0;
        mem_rvalid = 1'b0; exec_done = 1'b0; jump_req = 1'b0;
        jump_target = '0; jump_right = 1'b0;

        vt[0] = '{8'h05, 40'h01_00A_02_00B, 8'h01, 12'h00A, 8'h02, 12'h00B, 0, 0};
        vt[1] = '{8'hFF, 40'hA5_FFF_5A_001, 8'hA5, 12'hFFF, 8'h5A, 12'h001, 2, 1};
        vt[2] = '{8'h00, 40'h12_345_67_89A, 8'h12, 12'h345, 8'h67, 12'h89A, 7, 5};
        vt[3] = '{8'h80, 40'h00_000_FE_F00, 8'h00, 12'h000, 8'hFE, 12'hF00, 1, 0};

        tick();
        tick();
        reset = 1'b0;
        chk_zero("reset_state");

        exec_done = 1'b1; jump_req = 1'b1; mem_rvalid = 1'b1;
        tick();
        exec_done = 1'b0; jump_req = 1'b0; mem_rvalid = 1'b0;
        chk_zero("idle_ignore");
        tick();
        chk_zero("idle_ignore2");

        foreach (vt[v]) begin
            i0 = n_inc;
            r0 = n_rd;
            fetch(vt[v].pc, vt[v].data, vt[v].rdly);
            chk_issue("left", vt[v].irl, vt[v].marl);
            tick();
            chk("inc_once", inc_pc, 1'b0);
            chk_issue("left_hold", vt[v].irl, vt[v].marl);
            for (int k = 0; k < vt[v].edly; k++) begin
                tick();
                chk_issue("left_stall", vt[v].irl, vt[v].marl);
                chk("stall_inc", inc_pc, 1'b0);
            end
            done(1'b0);
            chk_issue("right", vt[v].irr, vt[v].marr);
            tick();
            chk_issue("right_hold", vt[v].irr, vt[v].marr);
            done(1'b0);
            chk("seq_idle_valid", instr_valid, 1'b0);
            chk("seq_idle_rd", mem_rd_en, 1'b0);
            chk("seq_inc_count", n_inc - i0, 1);
            chk("seq_rd_count", n_rd - r0, 1);
        end

        // left jump from ISSUE_L
        fetch(8'h10, 40'h03_111_04_222, 0);
        chk_issue("lj_left", 8'h03, 12'h111);
        jump_target = 8'h20; jump_right = 1'b0;
        done(1'b1);
        chk("lj_load", load_pc, 1'b1);
        chk("lj_addr", jump_addr, 8'h20);
        chk("lj_inc", inc_pc, 1'b0);
        chk("lj_valid", instr_valid, 1'b0);
        pc_addr = 8'h20;
        tick();
        chk("lj_load_once", load_pc, 1'b0);
        chk("lj_settle_rd", mem_rd_en, 1'b0);
        fetch(8'h20, 40'h05_333_06_444, 0);
        chk_issue("lj_new_left", 8'h05, 12'h333);
        done(1'b0);
        chk_issue("lj_new_right", 8'h06, 12'h444);
        done(1'b0);
        chk("lj_idle", instr_valid, 1'b0);

        // right jump taken from ISSUE_R
        fetch(8'h40, 40'h07_555_08_666, 0);
        done(1'b0);
        chk_issue("rj_right", 8'h08, 12'h666);
        jump_target = 8'h30; jump_right = 1'b1;
        done(1'b1);
        chk("rj_load", load_pc, 1'b1);
        chk("rj_addr", jump_addr, 8'h30);
        pc_addr = 8'h30;
        tick();
        fetch(8'h30, 40'h09_777_0A_888, 0);
        chk_issue("rj_only_right", 8'h0A, 12'h888);
        done(1'b0);
        chk("rj_idle", instr_valid, 1'b0);
        fetch(8'h31, 40'h0B_123_0C_456, 0);
        chk_issue("rj_flag_clear", 8'h0B, 12'h123);
        done(1'b0);
        done(1'b0);

        // halt has priority over a simultaneous jump
        fetch(8'h50, 40'hFF_000_0B_999, 0);
        chk_issue("halt_left", 8'hFF, 12'h000);
        jump_target = 8'h77;
        l0 = n_load;
        done(1'b1);
        chk("halt_flag", halted, 1'b1);
        chk("halt_valid", instr_valid, 1'b0);
        i0 = n_inc;
        r0 = n_rd;
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mem_rvalid = k[0];
            tick();
        end
        run = 1'b0;
        mem_rvalid = 1'b0;
        chk("halt_hold", halted, 1'b1);
        chk("halt_no_rd", n_rd - r0, 0);
        chk("halt_no_inc", n_inc - i0, 0);
        chk("halt_no_load", n_load - l0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("halt_reset");

        // reset in WAIT_MEM then a stale response
        pc_addr = 8'h60;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("midop_reset");
        mem_rdata = 40'h11_111_22_222;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk_zero("stale_rvalid");
        tick();
        chk_zero("stale_rvalid2");
        fetch(8'h60, 40'h13_ABC_14_DEF, 0);
        chk_issue("restart_left", 8'h13, 12'hABC);
        done(1'b0);
        chk_issue("restart_right", 8'h14, 12'hDEF);
        done(1'b0);
        chk("restart_idle", instr_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
